// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// State encoding, seven-segment pattern table and the power-of-ten helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low patterns for digits 9..0, bit 0 = segment a, bit 6 = segment g
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Single BCD digit to active-low seven-segment decoder with blanking.
// Non-decimal codes and an asserted blank both turn every segment off.
module seg7_dec
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = (blank || (digit > 4'd9)) ? SEG_BLANK : SEG_TABLE[digit];

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with saturation.
// Optional seven-segment outputs with leading-zero blanking under BIN2BCD_SEG7_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   HEX
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int REG_W = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned LIMIT = pow10(DIGITS) - 1;
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] f);
    logic [BCD_W-1:0] r;
    r = f;
    for (int k = 0; k < DIGITS; k++)
      if (f[4*k +: 4] >= 4'd5) r[4*k +: 4] = f[4*k +: 4] + 4'd3;
    return r;
  endfunction

  state_t           state;
  logic [REG_W-1:0] work;
  logic [REG_W-1:0] work_adj;
  logic [REG_W-1:0] work_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ovf_next;

  // Adjust precedes the shift; carry out of the top nibble falls off the left
  always_comb begin
    work_adj = {add3(work[REG_W-1 -: BCD_W]), work[WIDTH-1:0]};
    work_nxt = work_adj << 1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      ovf_next <= 1'b0;
      bcd      <= '0;
      work     <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work     <= {{BCD_W{1'b0}}, bin};
            ovf_next <= (32'(bin) > LIMIT);
            cnt      <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          // Results are loaded on entry to DONE so they are valid while done is high
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= ovf_next ? NINES : work_nxt[REG_W-1 -: BCD_W];
            ovf   <= ovf_next;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_SEG7_EN
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg_w;
  logic                lead;

  // A digit blanks only when it and every more significant digit are zero
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead     = lead && (bcd[4*k +: 4] == 4'd0);
      blank[k] = lead;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_dec u_dec (
      .digit(bcd[4*k +: 4]),
      .blank(blank[k]),
      .seg  (seg_w[7*k +: 7])
    );
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < DIGITS; k++)
        HEX[7*k +: 7] <= (k == 0) ? SEG_TABLE[0] : SEG_BLANK;
    end else begin
      HEX <= seg_w;
    end
  end
`endif

endmodule
